// File: rtl/fp_pkg.sv
// Shared floating point package: format widths, rounding-mode encoding,
// exponent constants and the rounding-mode decoder.
// Optional feature macro: FPROUND_RMM_EN (round-to-nearest-max-magnitude).
package fp;

  localparam int FPWID = 32;
  localparam int MSB   = FPWID - 1;
  localparam int EMSB  = 7;
  localparam int FMSB  = 22;

  typedef enum logic [2:0] {
    RM_RNE = 3'd0,
    RM_RTZ = 3'd1,
    RM_RDN = 3'd2,
    RM_RUP = 3'd3,
    RM_RMM = 3'd4
  } rnd_mode_t;

  localparam logic [EMSB:0] EXP_ONES = {(EMSB+1){1'b1}};
  localparam logic [EMSB:0] EXP_MAXF = {{EMSB{1'b1}}, 1'b0};
  localparam logic [EMSB:0] EXP_ONE  = {{EMSB{1'b0}}, 1'b1};

  // Map the raw 3-bit mode onto a supported mode; unused codes fall back to RNE.
  function automatic rnd_mode_t decode_rm(input logic [2:0] rm);
    rnd_mode_t m;
    case (rm)
      3'd1:    m = RM_RTZ;
      3'd2:    m = RM_RDN;
      3'd3:    m = RM_RUP;
`ifdef FPROUND_RMM_EN
      3'd4:    m = RM_RMM;
`endif
      default: m = RM_RNE;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/fp_round_dec.sv
// Combinational round-up decision from rounding mode, sign and the L/G/S bits.
// Optional feature macro: FPROUND_RMM_EN.
module fp_round_dec
  import fp::*;
(
  input  logic [2:0] rm,
  input  logic       sign,
  input  logic       l,
  input  logic       g,
  input  logic       s,
  output logic       rup
);

  // Select the increment condition for the decoded rounding mode.
  always_comb begin
    rup = 1'b0;
    case (decode_rm(rm))
      RM_RNE:  rup = g & (s | l);
      RM_RTZ:  rup = 1'b0;
      RM_RDN:  rup = sign & (g | s);
      RM_RUP:  rup = ~sign & (g | s);
`ifdef FPROUND_RMM_EN
      RM_RMM:  rup = g;
`endif
      default: rup = 1'b0;
    endcase
  end

endmodule

// File: rtl/fp_round_pipe.sv
// Three-stage IEEE 754 rounding pipeline fed by the normalizer.
// Optional feature macro: FPROUND_RMM_EN (rm=4 rounds to nearest, max magnitude).
// Handshake: valid-only. A beat is taken whenever valid_i=1 on a ce-enabled
// clock; there is no back-pressure. o and the flags are meaningful only while
// valid_o=1. ce=0 freezes every stage, including the valid shift register.
module fp_round_pipe
  import fp::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic           ce,
  input  logic           valid_i,
  input  logic [2:0]     rm,
  input  logic [MSB+3:0] i,
  input  logic           under_i,
  input  logic           inexact_i,
  output logic [MSB:0]   o,
  output logic           valid_o,
  output logic           overflow_o,
  output logic           underflow_o,
  output logic           inexact_o
);

  // Input field split.
  logic            in_sign;
  logic [EMSB:0]   in_exp;
  logic [FMSB+1:0] in_man;
  logic            in_g, in_s, in_rup;

  assign in_sign = i[MSB+3];
  assign in_exp  = i[MSB+2:FMSB+4];
  assign in_man  = i[FMSB+3:2];
  assign in_g    = i[1];
  assign in_s    = i[0];

  fp_round_dec u_dec (
    .rm   (rm),
    .sign (in_sign),
    .l    (i[2]),
    .g    (in_g),
    .s    (in_s),
    .rup  (in_rup)
  );

  // Stage 1 state.
  logic            s1_valid, s1_sign, s1_rup, s1_special, s1_gs, s1_under, s1_inex;
  logic [EMSB:0]   s1_exp;
  logic [FMSB+1:0] s1_man;
  rnd_mode_t       s1_mode;

  // Stage 2 state.
  logic            s2_valid, s2_sign, s2_special, s2_gs, s2_under, s2_inex;
  logic [EMSB:0]   s2_exp, s2_exp_p1;
  logic [FMSB+2:0] s2_sum;
  rnd_mode_t       s2_mode;

  // Stage 1: capture fields, decode mode, decide rounding, flag specials.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0; s1_sign <= 1'b0; s1_rup <= 1'b0; s1_special <= 1'b0;
      s1_gs <= 1'b0; s1_under <= 1'b0; s1_inex <= 1'b0;
      s1_exp <= '0; s1_man <= '0; s1_mode <= RM_RNE;
    end else if (ce) begin
      s1_valid   <= valid_i;
      s1_sign    <= in_sign;
      s1_exp     <= in_exp;
      s1_man     <= in_man;
      s1_special <= (in_exp == EXP_ONES);
      // NaN/Inf never increments.
      s1_rup     <= in_rup & (in_exp != EXP_ONES);
      s1_gs      <= in_g | in_s;
      s1_under   <= under_i;
      s1_inex    <= inexact_i;
      s1_mode    <= decode_rm(rm);
    end
  end

  // Stage 2: mantissa increment with carry, exponent+1 candidate.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid <= 1'b0; s2_sign <= 1'b0; s2_special <= 1'b0; s2_gs <= 1'b0;
      s2_under <= 1'b0; s2_inex <= 1'b0;
      s2_exp <= '0; s2_exp_p1 <= '0; s2_sum <= '0; s2_mode <= RM_RNE;
    end else if (ce) begin
      s2_valid   <= s1_valid;
      s2_sign    <= s1_sign;
      s2_special <= s1_special;
      s2_gs      <= s1_gs;
      s2_under   <= s1_under;
      s2_inex    <= s1_inex;
      s2_exp     <= s1_exp;
      s2_exp_p1  <= s1_exp + EXP_ONE;
      s2_sum     <= {1'b0, s1_man} + {{(FMSB+2){1'b0}}, s1_rup};
      s2_mode    <= s1_mode;
    end
  end

  // Stage 3 combinational: exponent select, overflow substitution, flags.
  logic [EMSB:0] r_exp;
  logic [FMSB:0] r_frac;
  logic          r_ovf, r_inex, r_to_inf;

  always_comb begin
    r_exp    = s2_exp;
    r_frac   = s2_sum[FMSB:0];
    r_ovf    = 1'b0;
    r_to_inf = 1'b0;
    r_inex   = 1'b0;
    if (!s2_special) begin
      if (s2_sum[FMSB+2]) begin
        r_exp  = s2_exp_p1;
        r_frac = '0;
      end else if ((s2_exp == '0) && s2_sum[FMSB+1]) begin
        // Denormal rounded up into the smallest normal.
        r_exp = EXP_ONE;
      end
      r_ovf = (r_exp == EXP_ONES);
      case (s2_mode)
        RM_RNE:  r_to_inf = 1'b1;
        RM_RUP:  r_to_inf = ~s2_sign;
        RM_RDN:  r_to_inf = s2_sign;
`ifdef FPROUND_RMM_EN
        RM_RMM:  r_to_inf = 1'b1;
`endif
        default: r_to_inf = 1'b0;
      endcase
      if (r_ovf) begin
        if (r_to_inf) begin
          r_exp  = EXP_ONES;
          r_frac = '0;
        end else begin
          r_exp  = EXP_MAXF;
          r_frac = '1;
        end
      end
      r_inex = s2_inex | s2_gs | r_ovf;
    end
  end

  // Stage 3 register: packed result and flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_o <= 1'b0; o <= '0;
      overflow_o <= 1'b0; underflow_o <= 1'b0; inexact_o <= 1'b0;
    end else if (ce) begin
      valid_o     <= s2_valid;
      o           <= {s2_sign, r_exp, r_frac};
      overflow_o  <= r_ovf;
      inexact_o   <= r_inex;
      underflow_o <= s2_under & r_inex;
    end
  end

endmodule

// File: tb/tb_fp_round_pipe.sv
// Self-checking bench for fp_round_pipe: directed vectors, ce stalls, reset
// flush and random beats, checked through an expected-value queue.
module tb_fp_round_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ce = 1'b1;
  logic        valid_i = 1'b0;
  logic [2:0]  rm = '0;
  logic [34:0] i = '0;
  logic        under_i = 1'b0;
  logic        inexact_i = 1'b0;
  logic [31:0] o;
  logic        valid_o, overflow_o, underflow_o, inexact_o;

  fp_round_pipe dut (
    .clk(clk), .rst(rst), .ce(ce), .valid_i(valid_i), .rm(rm), .i(i),
    .under_i(under_i), .inexact_i(inexact_i), .o(o), .valid_o(valid_o),
    .overflow_o(overflow_o), .underflow_o(underflow_o), .inexact_o(inexact_o)
  );

  // Clock and ce-cycle bookkeeping.
  always #5 clk = ~clk;

  int   ce_cnt = 0;
  logic last_edge_ce = 1'b0;
  always @(posedge clk) begin
    last_edge_ce = ce && !rst;
    if (ce && !rst) ce_cnt++;
  end

  // Scoreboard: {o, overflow, underflow, inexact} plus issue stamp.
  logic [34:0] exp_q[$];
  int          stamp_q[$];
  int          n_checks = 0;
  int          n_pass = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  // Reference model built straight from the rounding rules.
  function automatic logic [34:0] model(input logic sign, input logic [7:0] e_in,
      input logic [23:0] man, input logic g, input logic s, input logic [2:0] rmode,
      input logic under, input logic inex);
    int  m, e, md;
    logic rup, ovf, inf, ix, uf;
    if (e_in == 8'hFF) return {sign, e_in, man[22:0], 3'b000};
    md = (rmode <= 3'd3) ? int'(rmode) : 0;
`ifdef FPROUND_RMM_EN
    if (rmode == 3'd4) md = 4;
`endif
    case (md)
      0: rup = g & (s | man[0]);
      1: rup = 1'b0;
      2: rup = sign & (g | s);
      3: rup = !sign & (g | s);
      default: rup = g;
    endcase
    m = int'(man) + int'(rup);
    e = int'(e_in);
    if (m >= (1 << 24)) begin e = e + 1; m = 0; end
    else if (e == 0 && m >= (1 << 23)) e = 1;
    ovf = (e == 255);
    if (ovf) begin
      inf = (md == 0) || (md == 4) || (md == 3 && !sign) || (md == 2 && sign);
      if (inf) begin e = 255; m = 0; end
      else begin e = 254; m = (1 << 23) - 1; end
    end
    ix = inex | g | s | ovf;
    uf = under & ix;
    return {sign, e[7:0], m[22:0], ovf, uf, ix};
  endfunction

  // Driver: present one beat for one clock (caller keeps ce high).
  task automatic send(input logic sign, input logic [7:0] e, input logic [23:0] man,
      input logic g, input logic s, input logic [2:0] rmode,
      input logic under, input logic inex);
    i = {sign, e, man, g, s};
    rm = rmode;
    under_i = under;
    inexact_i = inex;
    valid_i = 1'b1;
    exp_q.push_back(model(sign, e, man, g, s, rmode, under, inex));
    stamp_q.push_back(ce_cnt);
    @(posedge clk); #1;
    valid_i = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Monitor: reset values, output order, latency and stale beats.
  always @(negedge clk) begin
    logic [34:0] item;
    int          st;
    if (rst) begin
      check("rst_valid", valid_o, 0);
      check("rst_o", o, 0);
      check("rst_flags", {overflow_o, underflow_o, inexact_o}, 0);
    end else if (last_edge_ce && valid_o) begin
      if (exp_q.size() == 0) begin
        check("stale_beat", valid_o, 0);
      end else begin
        item = exp_q.pop_front();
        st = stamp_q.pop_front();
        check("o", o, item[34:3]);
        check("overflow", overflow_o, item[2]);
        check("underflow", underflow_o, item[1]);
        check("inexact", inexact_o, item[0]);
        check("latency", ce_cnt - st, 3);
      end
    end
  end

  // Stimulus.
  initial begin
    logic [7:0] e;
    int         w;
    idle(2);
    rst = 1'b0;
    idle(1);

    // Directed vectors.
    send(0, 8'h80, 24'h800000, 1, 0, 3'd0, 0, 0);
    send(0, 8'h80, 24'h800001, 1, 0, 3'd0, 0, 0);
    send(0, 8'h7F, 24'hFFFFFF, 1, 1, 3'd3, 0, 0);
    send(0, 8'hFE, 24'hFFFFFF, 1, 0, 3'd0, 0, 0);
    send(0, 8'hFE, 24'hFFFFFF, 1, 0, 3'd1, 0, 0);
    send(1, 8'hFE, 24'hFFFFFF, 1, 0, 3'd3, 0, 0);
    send(1, 8'hFE, 24'hFFFFFF, 1, 0, 3'd2, 0, 0);
    send(1, 8'h00, 24'h7FFFFF, 1, 1, 3'd2, 1, 0);
    send(0, 8'hFF, 24'hC00001, 1, 1, 3'd3, 1, 1);
    send(0, 8'h40, 24'h812345, 1, 0, 3'd4, 0, 0);
    send(1, 8'h40, 24'h812344, 1, 0, 3'd6, 0, 1);
    send(0, 8'h00, 24'h000010, 0, 0, 3'd1, 1, 1);
    idle(5);

    // ce stall mid-stream.
    send(0, 8'h81, 24'h900000, 1, 1, 3'd0, 0, 0);
    send(1, 8'h82, 24'hA00001, 0, 1, 3'd2, 0, 0);
    ce = 1'b0;
    idle(2);
    ce = 1'b1;
    send(0, 8'h83, 24'hBFFFFF, 1, 0, 3'd4, 0, 0);
    idle(6);

    // Reset with two beats in flight; they must never appear.
    send(0, 8'h10, 24'h800000, 0, 0, 3'd0, 0, 0);
    send(0, 8'h11, 24'h800000, 0, 0, 3'd0, 0, 0);
    rst = 1'b1;
    exp_q.delete();
    stamp_q.delete();
    idle(2);
    rst = 1'b0;
    idle(6);
    send(1, 8'h20, 24'h8FFFFF, 1, 1, 3'd3, 0, 0);
    idle(4);

    // Random beats with random ce gaps.
    for (int k = 0; k < 60; k++) begin
      case ($urandom_range(0, 4))
        0: e = 8'h00;
        1: e = 8'hFE;
        2: e = 8'hFF;
        3: e = 8'h01;
        default: e = 8'($urandom_range(1, 254));
      endcase
      send($urandom_range(0, 1), e,
           {(e != 0) ? 1'b1 : 1'($urandom_range(0, 1)), 23'($urandom_range(0, 32'h7FFFFF))},
           $urandom_range(0, 1), $urandom_range(0, 1), 3'($urandom_range(0, 7)),
           (e == 0), $urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) begin
        ce = 1'b0;
        idle($urandom_range(1, 3));
        ce = 1'b1;
      end
    end

    // Drain with a bounded wait.
    w = 0;
    while (exp_q.size() != 0 && w < 50) begin idle(1); w++; end
    check("drain", exp_q.size(), 0);
    idle(2);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
